// File: rtl/framebuffer_writer_pkg.sv
// Shared constants and types for the framebuffer stream writer.
// AXI response codes, burst type and the FSM state encoding.
package framebuffer_writer_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam int unsigned BOUNDARY_4K = 4096;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        DONE
    } state_t;

endpackage

// File: rtl/framebuffer_burst_planner.sv
// Burst length planner: min of max burst, beats left and room to the 4 KB page end.
// i_page_off is the low 12 bits of the (beat-aligned) burst start address.
module framebuffer_burst_planner
    import framebuffer_writer_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int BPB           = 8,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [11:0]           i_page_off,
    input  logic [ADDR_WIDTH-1:0] i_remaining,
    output logic [8:0]            o_len
);

    localparam int BPB_LG = $clog2(BPB);

    logic [12:0] w_room_bytes;
    logic [12:0] w_room_beats;

    always_comb begin
        w_room_bytes = 13'(BOUNDARY_4K) - {1'b0, i_page_off};
        w_room_beats = w_room_bytes >> BPB_LG;
        o_len        = 9'(MAX_BURST_LEN);
        if (i_remaining < ADDR_WIDTH'(o_len)) begin
            o_len = 9'(i_remaining);
        end
        if (w_room_beats < 13'(o_len)) begin
            o_len = 9'(w_room_beats);
        end
    end

endmodule

// File: rtl/framebuffer_stream_writer.sv
// Writes a framebuffer AXI-Stream transfer to memory via AXI4 INCR bursts.
// One burst in flight; stream data passes straight through to the W channel.
module framebuffer_stream_writer
    import framebuffer_writer_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int STRB_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 16,
    parameter int ID_WIDTH      = 4
) (
    input  logic                      aclk,
    input  logic                      resetn,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [STRB_WIDTH-1:0]     s_axis_tstrb,
    input  logic                      s_tstart,
    input  logic [ADDR_WIDTH-1:0]     s_taddr,
    input  logic [ADDR_WIDTH-1:0]     s_tbytes,
    output logic                      s_tdone,
    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic                      error
);

    localparam int BPB    = DATA_WIDTH / 8;
    localparam int BPB_LG = $clog2(BPB);
    localparam int SUB    = DATA_WIDTH / STRB_WIDTH / 8;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   r_remaining;
    logic [8:0]              r_cnt;
    logic [8:0]              r_len;
    logic                    r_armed;
    logic                    r_error;
    logic                    r_pad;

    logic [ADDR_WIDTH:0]     w_bytes_up;
    logic [ADDR_WIDTH-1:0]   w_beats_total;
    logic [8:0]              w_len;
    logic [BPB-1:0]          w_strb_exp;
    logic                    w_start;
    logic                    w_in_data;
    logic                    w_whs;
    logic                    w_bhs;
    logic                    w_last_beat;
    logic                    w_unused_bid;

    assign w_unused_bid  = ^m_axi_bid;
    assign w_bytes_up    = {1'b0, s_tbytes} + (ADDR_WIDTH+1)'(BPB - 1);
    assign w_beats_total = ADDR_WIDTH'(w_bytes_up >> BPB_LG);

    framebuffer_burst_planner #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .BPB           (BPB),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_planner (
        .i_page_off  (r_addr[11:0]),
        .i_remaining (r_remaining),
        .o_len       (w_len)
    );

    for (genvar i = 0; i < BPB; i++) begin : g_strb
        assign w_strb_exp[i] = s_axis_tstrb[i / SUB];
    end

    assign w_start     = (r_state == IDLE) && s_tstart && r_armed;
    assign w_in_data   = (r_state == DATA);
    assign w_last_beat = (r_remaining == ADDR_WIDTH'(1));

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = 8'(w_len - 9'd1);
    assign m_axi_awsize  = 3'(BPB_LG);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awvalid = (r_state == ADDR);

    assign m_axi_wvalid  = w_in_data && (r_pad || s_axis_tvalid);
    assign s_axis_tready = w_in_data && m_axi_wready && !r_pad;
    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = r_pad ? '0 : w_strb_exp;
    assign m_axi_wlast   = (r_cnt == 9'd1);
    assign m_axi_bready  = (r_state == RESP);
    assign s_tdone       = (r_state == DONE);
    assign error         = r_error;

    assign w_whs = m_axi_wvalid && m_axi_wready;
    assign w_bhs = m_axi_bready && m_axi_bvalid;

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = (w_beats_total == '0) ? DONE : ADDR;
                end
            end
            ADDR: begin
                if (m_axi_awready) w_next = DATA;
            end
            DATA: begin
                if (w_whs && r_cnt == 9'd1) w_next = RESP;
            end
            RESP: begin
                if (m_axi_bvalid) begin
                    w_next = (r_remaining == '0) ? DONE : ADDR;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_armed     <= 1'b1;
            r_error     <= 1'b0;
            r_pad       <= 1'b0;
        end else begin
            if (w_start) begin
                r_armed <= 1'b0;
            end else if (!s_tstart) begin
                r_armed <= 1'b1;
            end
            if (w_start) begin
                r_addr      <= s_taddr;
                r_remaining <= w_beats_total;
                r_error     <= 1'b0;
                r_pad       <= 1'b0;
            end
            if (r_state == ADDR && m_axi_awready) begin
                r_cnt <= w_len;
                r_len <= w_len;
            end
            // Early tlast pads out the transfer; a missing tlast only flags.
            if (w_whs) begin
                r_cnt       <= r_cnt - 9'd1;
                r_remaining <= r_remaining - ADDR_WIDTH'(1);
                if (!r_pad) begin
                    if (s_axis_tlast && !w_last_beat) begin
                        r_error <= 1'b1;
                        r_pad   <= 1'b1;
                    end else if (!s_axis_tlast && w_last_beat) begin
                        r_error <= 1'b1;
                    end
                end
            end
            if (w_bhs) begin
                if (m_axi_bresp != RESP_OKAY) r_error <= 1'b1;
                r_addr <= r_addr + (ADDR_WIDTH'(r_len) << BPB_LG);
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_stream_writer.sv
// Directed bench for framebuffer_stream_writer with a simple AXI slave and stream source.
module tb_framebuffer_stream_writer;

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tstrb = '0;
    logic        s_tstart = 1'b0;
    logic [31:0] s_taddr = '0;
    logic [31:0] s_tbytes = '0;
    logic        s_tdone;
    logic [3:0]  m_axi_awid;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [3:0]  m_axi_bid = '0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic        error;

    framebuffer_stream_writer dut (
        .aclk(aclk), .resetn(resetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .s_axis_tstrb(s_axis_tstrb),
        .s_tstart(s_tstart), .s_taddr(s_taddr), .s_tbytes(s_tbytes),
        .s_tdone(s_tdone),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .error(error)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    logic [63:0] src_data [64];
    logic [7:0]  src_strb [64];
    int          src_n = 0;
    int          src_idx = 0;
    int          src_last = -1;

    logic [31:0] aw_addr_q  [16];
    logic [7:0]  aw_len_q   [16];
    logic [2:0]  aw_size_q  [16];
    logic [1:0]  aw_burst_q [16];
    int          aw_n = 0;
    logic [63:0] w_data_q [64];
    logic [7:0]  w_strb_q [64];
    logic        w_last_q [64];
    int          w_n = 0;
    logic [1:0]  resp_tab [4];
    int          b_n = 0;
    bit          b_pend = 0;
    int          done_n = 0;
    int          done_cyc = 0;
    bit          wr_toggle = 0;
    int          cyc = 0;
    int          sidx;

    // Slave and source: drive on negedge, then sample what the next posedge will accept.
    initial begin
        foreach (resp_tab[i]) resp_tab[i] = 2'b00;
        forever begin
            @(negedge aclk);
            cyc++;
            sidx = (src_idx < 64) ? src_idx : 0;
            s_axis_tvalid = (src_idx < src_n);
            s_axis_tdata  = src_data[sidx];
            s_axis_tstrb  = src_strb[sidx];
            s_axis_tlast  = (src_idx == src_last);
            m_axi_awready = 1'b1;
            m_axi_wready  = wr_toggle ? cyc[0] : 1'b1;
            m_axi_bvalid  = b_pend;
            m_axi_bresp   = resp_tab[b_n & 3];
            #1;
            if (resetn) begin
                if (m_axi_awvalid && m_axi_awready && aw_n < 16) begin
                    aw_addr_q[aw_n]  = m_axi_awaddr;
                    aw_len_q[aw_n]   = m_axi_awlen;
                    aw_size_q[aw_n]  = m_axi_awsize;
                    aw_burst_q[aw_n] = m_axi_awburst;
                    aw_n++;
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    b_pend = 0;
                    b_n++;
                end
                if (m_axi_wvalid && m_axi_wready && w_n < 64) begin
                    w_data_q[w_n] = m_axi_wdata;
                    w_strb_q[w_n] = m_axi_wstrb;
                    w_last_q[w_n] = m_axi_wlast;
                    w_n++;
                    if (m_axi_wlast) b_pend = 1;
                end
                if (s_axis_tvalid && s_axis_tready) src_idx++;
                if (s_tdone) begin
                    done_n++;
                    done_cyc = cyc;
                end
            end else begin
                b_pend = 0;
            end
        end
    end

    task automatic clear_env();
        @(posedge aclk); #2;
        src_n = 0; src_idx = 0; src_last = -1;
        aw_n = 0; w_n = 0; b_n = 0; done_n = 0;
        wr_toggle = 0;
        foreach (resp_tab[i]) resp_tab[i] = 2'b00;
    endtask

    task automatic fill_src(input int n, input int last, input logic [31:0] seed);
        for (int i = 0; i < n; i++) begin
            src_data[i] = {seed, 32'(i)};
            src_strb[i] = 8'hFF;
        end
        src_n = n; src_idx = 0; src_last = last;
    endtask

    task automatic run_xfer(input logic [31:0] a, input logic [31:0] b, output bit ok);
        @(posedge aclk); #2;
        s_taddr = a; s_tbytes = b; s_tstart = 1'b1;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge aclk); #2;
            if (done_n > 0) begin
                ok = 1;
                break;
            end
        end
        s_tstart = 1'b0;
        repeat (2) @(posedge aclk);
        #2;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL xfer_timeout addr=%h got no s_tdone, need one", a);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        tests++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b000) begin
            fails++;
            $display("FAIL reset_axi got %b need 000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_bready});
        end
        tests++;
        if ({s_tdone, error, s_axis_tready} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctl got %b need 000", {s_tdone, error, s_axis_tready});
        end
        resetn = 1'b1;
    endtask

    task automatic test_two_bursts();
        bit ok;
        int bad;
        clear_env();
        fill_src(32, 31, 32'hD0D0_0001);
        run_xfer(32'h1000, 32'd256, ok);
        tests++;
        if (aw_n !== 2 || aw_addr_q[0] !== 32'h1000 || aw_len_q[0] !== 8'd15) begin
            fails++;
            $display("FAIL two_aw0 got n=%0d %h/%0d need 2 00001000/15",
                     aw_n, aw_addr_q[0], aw_len_q[0]);
        end
        tests++;
        if (aw_addr_q[1] !== 32'h1080 || aw_len_q[1] !== 8'd15) begin
            fails++;
            $display("FAIL two_aw1 got %h/%0d need 00001080/15", aw_addr_q[1], aw_len_q[1]);
        end
        tests++;
        if (aw_size_q[0] !== 3'd3 || aw_burst_q[0] !== 2'b01) begin
            fails++;
            $display("FAIL two_size got %0d/%0d need 3/1", aw_size_q[0], aw_burst_q[0]);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (w_data_q[i] !== {32'hD0D0_0001, 32'(i)} || w_strb_q[i] !== 8'hFF ||
                w_last_q[i] !== (i == 15 || i == 31))
                bad++;
        end
        tests++;
        if (w_n !== 32 || bad !== 0) begin
            fails++;
            $display("FAIL two_wbeats got n=%0d bad=%0d need 32/0", w_n, bad);
        end
        tests++;
        if (done_n !== 1 || error !== 1'b0 || b_n !== 2) begin
            fails++;
            $display("FAIL two_done got done=%0d err=%b b=%0d need 1/0/2", done_n, error, b_n);
        end
    endtask

    task automatic test_4k_split();
        bit ok;
        clear_env();
        fill_src(16, 15, 32'h4C4C_0002);
        run_xfer(32'h1FC0, 32'd128, ok);
        tests++;
        if (aw_n !== 2 || aw_addr_q[0] !== 32'h1FC0 || aw_len_q[0] !== 8'd7 ||
            aw_addr_q[1] !== 32'h2000 || aw_len_q[1] !== 8'd7) begin
            fails++;
            $display("FAIL split_aw got n=%0d %h/%0d %h/%0d need 2 00001fc0/7 00002000/7",
                     aw_n, aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
        end
        tests++;
        if (w_n !== 16 || w_last_q[7] !== 1'b1 || w_data_q[8] !== {32'h4C4C_0002, 32'd8}) begin
            fails++;
            $display("FAIL split_w got n=%0d last7=%b d8=%h need 16/1", w_n, w_last_q[7],
                     w_data_q[8]);
        end
    endtask

    task automatic test_zero_bytes();
        int start_cyc;
        clear_env();
        s_taddr = 32'h7000; s_tbytes = 32'd0; s_tstart = 1'b1;
        start_cyc = cyc;
        repeat (5) @(posedge aclk);
        #2;
        tests++;
        if (done_n !== 1 || aw_n !== 0 || w_n !== 0) begin
            fails++;
            $display("FAIL zero_held got done=%0d aw=%0d w=%0d need 1/0/0", done_n, aw_n, w_n);
        end
        tests++;
        if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
            fails++;
            $display("FAIL zero_latency got %0d cycles need 1..2", done_cyc - start_cyc);
        end
        s_tstart = 1'b0;
        repeat (2) @(posedge aclk);
        #2;
        s_tstart = 1'b1;
        repeat (3) @(posedge aclk);
        #2;
        s_tstart = 1'b0;
        tests++;
        if (done_n !== 2) begin
            fails++;
            $display("FAIL zero_rearm got done=%0d need 2", done_n);
        end
    endtask

    task automatic test_early_tlast();
        bit ok;
        int bad;
        clear_env();
        fill_src(8, 4, 32'hE1E1_0003);
        wr_toggle = 1;
        run_xfer(32'h3000, 32'd64, ok);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5 && (w_data_q[i] !== {32'hE1E1_0003, 32'(i)} || w_strb_q[i] !== 8'hFF))
                bad++;
            if (i >= 5 && w_strb_q[i] !== 8'h00)
                bad++;
        end
        tests++;
        if (aw_n !== 1 || aw_len_q[0] !== 8'd7 || w_n !== 8 || bad !== 0) begin
            fails++;
            $display("FAIL tlast_beats got aw=%0d len=%0d w=%0d bad=%0d need 1/7/8/0",
                     aw_n, aw_len_q[0], w_n, bad);
        end
        tests++;
        if (error !== 1'b1 || src_idx !== 5 || w_last_q[7] !== 1'b1) begin
            fails++;
            $display("FAIL tlast_err got err=%b consumed=%0d last=%b need 1/5/1",
                     error, src_idx, w_last_q[7]);
        end
        clear_env();
        fill_src(8, -1, 32'hE1E1_0004);
        run_xfer(32'h3100, 32'd64, ok);
        tests++;
        if (error !== 1'b1 || w_n !== 8 || src_idx !== 8) begin
            fails++;
            $display("FAIL notlast got err=%b w=%0d consumed=%0d need 1/8/8", error, w_n, src_idx);
        end
    endtask

    task automatic test_slverr();
        bit ok;
        clear_env();
        fill_src(32, 31, 32'h5E5E_0005);
        resp_tab[1] = 2'b10;
        run_xfer(32'h8000, 32'd256, ok);
        tests++;
        if (done_n !== 1 || error !== 1'b1 || aw_n !== 2) begin
            fails++;
            $display("FAIL slverr got done=%0d err=%b aw=%0d need 1/1/2", done_n, error, aw_n);
        end
        clear_env();
        run_xfer(32'h9000, 32'd0, ok);
        tests++;
        if (error !== 1'b0) begin
            fails++;
            $display("FAIL slverr_clear got err=%b need 0", error);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        int bad;
        clear_env();
        fill_src(16, 15, 32'hAB00_0006);
        @(posedge aclk); #2;
        s_taddr = 32'h5000; s_tbytes = 32'd128; s_tstart = 1'b1;
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk); #3;
            if (w_n >= 3) begin
                hit = 1;
                break;
            end
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL rst_mid_wait got w=%0d need 3", w_n);
        end
        resetn = 1'b0;
        #1;
        tests++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_tdone} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_mid_drop got %b need 0000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_tdone});
        end
        s_tstart = 1'b0;
        clear_env();
        repeat (2) @(posedge aclk);
        #2;
        resetn = 1'b1;
        fill_src(8, 7, 32'hAB00_0007);
        run_xfer(32'h6000, 32'd64, ok);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (w_data_q[i] !== {32'hAB00_0007, 32'(i)}) bad++;
        tests++;
        if (aw_n !== 1 || aw_addr_q[0] !== 32'h6000 || aw_len_q[0] !== 8'd7 ||
            w_n !== 8 || bad !== 0 || error !== 1'b0 || done_n !== 1) begin
            fails++;
            $display("FAIL rst_after got aw=%0d %h/%0d w=%0d bad=%0d err=%b done=%0d",
                     aw_n, aw_addr_q[0], aw_len_q[0], w_n, bad, error, done_n);
        end
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_4k_split();
        test_zero_bytes();
        test_early_tlast();
        test_slverr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
